// File: rtl/maze_pkg.sv
// maze_pkg: shared definitions for the maze cell server.
//   - Cell word layout (wall bit, collectible type field)
//   - Collectible type codes
//   - Maze geometry
//   - Respawn engine state encoding
//   - Helper that maps two random bits onto a collectible type
package maze_pkg;

  localparam int MAZE_SIZE     = 16;

  localparam int CELL_WALL_BIT = 0;
  localparam int CELL_TYPE_LSB = 1;
  localparam int CELL_TYPE_MSB = 3;

  localparam logic [2:0] TYPE_NONE = 3'b000;
  localparam logic [2:0] TYPE_A    = 3'b001;
  localparam logic [2:0] TYPE_B    = 3'b010;
  localparam logic [2:0] TYPE_C    = 3'b011;

  typedef enum logic [1:0] {
    R_IDLE,
    R_READ,
    R_CHECK,
    R_WRITE
  } respawn_state_e;

  // Two random bits pick the respawned collectible; 2'b11 folds back onto
  // TYPE_A, so TYPE_A appears twice as often as the other two.
  function automatic logic [2:0] cell_type_for(input logic [1:0] sel);
    case (sel)
      2'b00:   cell_type_for = TYPE_A;
      2'b01:   cell_type_for = TYPE_B;
      2'b10:   cell_type_for = TYPE_C;
      default: cell_type_for = TYPE_A;
    endcase
  endfunction

endpackage

// File: rtl/respawn_lfsr.sv
// respawn_lfsr: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, period 255) that
// picks respawn candidate cells. Never reaches zero from a non-zero seed.
// Ports:
//   mvmt_clk  in   clock
//   reset     in   async active-high reset, loads SEED
//   advance   in   step the sequence by one on the next edge
//   value     out  current 8-bit LFSR state
module respawn_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       mvmt_clk,
  input  logic       reset,
  input  logic       advance,
  output logic [7:0] value
);

  logic feedback;

  assign feedback = value[7] ^ value[5] ^ value[4] ^ value[3];

  always_ff @(posedge mvmt_clk or posedge reset) begin
    if (reset) begin
      value <= SEED;
    end else if (advance) begin
      value <= {value[6:0], feedback};
    end
  end

endmodule

// File: rtl/maze_cell_server.sv
// maze_cell_server: owner of the single port of the 256x9 maze BRAM.
// Serves player lookups and collectible-clear writes, counts collected
// items, and runs a background respawn engine that only uses port cycles
// the player does not need (no write, and the lookup address unchanged, so
// the registered read data is still valid).
// Ports:
//   mvmt_clk, reset          clock / async active-high reset
//   en                       game running; gates timer, FSM, LFSR, writes
//   rd_addr / rd_data        player lookup, rd_data two edges after rd_addr
//   wr_en/wr_addr/wr_data    player collectible-clear write
//   player_addr              player's cell, never chosen for respawn
//   respawn_en               allows new respawn attempts
//   mem_addr/mem_we/mem_din  BRAM port (combinational)
//   mem_dout                 BRAM read data, one cycle after mem_addr
//   collected_count          collectibles removed and not yet respawned
//   respawn_busy             respawn engine is mid-attempt
module maze_cell_server
  import maze_pkg::*;
#(
  parameter int         ADDR_W         = 8,
  parameter int         DATA_W         = 9,
  parameter int         RESPAWN_PERIOD = 1024,
  parameter int         MAX_TRIES      = 16,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic              mvmt_clk,
  input  logic              reset,
  input  logic              en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] player_addr,
  input  logic              respawn_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [7:0]        collected_count,
  output logic              respawn_busy
);

  localparam int TIMER_W = (RESPAWN_PERIOD > 1) ? $clog2(RESPAWN_PERIOD) : 1;
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RESPAWN_PERIOD - 1);
  localparam logic [TRY_W-1:0]   TRY_LAST   = TRY_W'(MAX_TRIES - 1);

  respawn_state_e      state, state_next;
  logic [TIMER_W-1:0]  timer;
  logic [TRY_W-1:0]    tries;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                read_q;
  logic [7:0]          lfsr;
  logic                lfsr_adv;
  logic                player_wr;
  logic                grant;
  logic                trigger;
  logic                cand_free;
  logic                rsp_write;
  logic                port_is_read;

  respawn_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .mvmt_clk (mvmt_clk),
    .reset    (reset),
    .advance  (lfsr_adv),
    .value    (lfsr)
  );

  assign player_wr = wr_en && en;
  // A stable lookup address means rd_data already holds the right word, so
  // the engine can borrow this cycle without the player noticing.
  assign grant     = en && !wr_en && (rd_addr == rd_addr_q);
  assign trigger   = en && (timer == TIMER_LAST) && respawn_en &&
                     (collected_count != 8'd0) && (state == R_IDLE);
  assign cand_free = !mem_dout[CELL_WALL_BIT] &&
                     (mem_dout[CELL_TYPE_MSB:CELL_TYPE_LSB] == TYPE_NONE) &&
                     (ADDR_W'(lfsr) != player_addr);
  assign lfsr_adv  = rsp_write || (en && (state == R_CHECK) && !cand_free);
  assign respawn_busy = (state != R_IDLE);

  always_ff @(posedge mvmt_clk or posedge reset) begin
    if (reset) begin
      state <= R_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Everything holds while en is low; a failed check retries until the
  // candidate budget is spent.
  always_comb begin
    state_next = state;
    if (en) begin
      case (state)
        R_IDLE:  if (trigger) state_next = R_READ;
        R_READ:  if (grant) state_next = R_CHECK;
        R_CHECK: begin
          if (cand_free)             state_next = R_WRITE;
          else if (tries == TRY_LAST) state_next = R_IDLE;
          else                        state_next = R_READ;
        end
        R_WRITE: if (grant) state_next = R_IDLE;
        default: state_next = R_IDLE;
      endcase
    end
  end

  // Port mux: player write, then respawn access, then player read. The
  // port is forced idle during reset so an abandoned attempt never writes.
  always_comb begin
    mem_addr     = rd_addr;
    mem_we       = 1'b0;
    mem_din      = '0;
    rsp_write    = 1'b0;
    port_is_read = 1'b1;
    if (reset) begin
      mem_addr     = '0;
      port_is_read = 1'b0;
    end else if (player_wr) begin
      mem_addr     = wr_addr;
      mem_we       = 1'b1;
      mem_din      = wr_data;
      port_is_read = 1'b0;
    end else if (grant && (state == R_READ)) begin
      mem_addr     = ADDR_W'(lfsr);
      port_is_read = 1'b0;
    end else if (grant && (state == R_WRITE)) begin
      mem_addr     = ADDR_W'(lfsr);
      mem_we       = 1'b1;
      mem_din      = {{(DATA_W-4){1'b0}}, cell_type_for(lfsr[1:0]), 1'b0};
      rsp_write    = 1'b1;
      port_is_read = 1'b0;
    end
  end

  // rd_data only reloads from the BRAM after a genuine player-read cycle;
  // a write to the address being looked up is forwarded straight through.
  always_ff @(posedge mvmt_clk or posedge reset) begin
    if (reset) begin
      rd_data   <= '0;
      rd_addr_q <= '0;
      read_q    <= 1'b0;
    end else begin
      rd_addr_q <= rd_addr;
      read_q    <= port_is_read;
      if (player_wr && (wr_addr == rd_addr)) begin
        rd_data <= wr_data;
      end else if (read_q) begin
        rd_data <= mem_dout;
      end
    end
  end

  // Player clears count up (saturating), respawns count down; both in the
  // same cycle cancel out.
  always_ff @(posedge mvmt_clk or posedge reset) begin
    if (reset) begin
      collected_count <= 8'd0;
    end else begin
      case ({player_wr, rsp_write})
        2'b10: if (collected_count != 8'hFF) collected_count <= collected_count + 8'd1;
        2'b01: if (collected_count != 8'h00) collected_count <= collected_count - 8'd1;
        default: collected_count <= collected_count;
      endcase
    end
  end

  // Period timer and per-attempt candidate counter.
  always_ff @(posedge mvmt_clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
      tries <= '0;
    end else if (en) begin
      timer <= (timer == TIMER_LAST) ? '0 : timer + TIMER_W'(1);
      if (trigger) begin
        tries <= '0;
      end else if ((state == R_CHECK) && !cand_free && (tries != TRY_LAST)) begin
        tries <= tries + TRY_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_maze_cell_server.sv
// tb_maze_cell_server: directed bench for maze_cell_server with a BRAM model.
// Port events (writes, respawn reads) are checked against a scoreboard of
// expected events; rd_data is checked against a queue of expected words.
module tb_maze_cell_server;

  localparam int BENCH_PERIOD = 8;

  logic       mvmt_clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] rd_addr;
  logic [8:0] rd_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [8:0] wr_data;
  logic [7:0] player_addr;
  logic       respawn_en;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [8:0] mem_din;
  logic [8:0] mem_dout;
  logic [7:0] collected_count;
  logic       respawn_busy;

  logic       load_en;
  logic [7:0] load_addr;
  logic [8:0] load_val;
  logic       wall_mode;
  logic [8:0] mem [0:255];

  int checks = 0;
  int errors = 0;
  int en_cycles = 0;
  int events_seen = 0;
  int ev_base;
  int n;
  logic [7:0]  lfsr_m = 8'hA5;
  logic [7:0]  a;
  logic [17:0] ev_q [$];
  logic [8:0]  rd_q [$];

  maze_cell_server #(
    .ADDR_W         (8),
    .DATA_W         (9),
    .RESPAWN_PERIOD (BENCH_PERIOD),
    .MAX_TRIES      (16),
    .LFSR_SEED      (8'hA5)
  ) dut (
    .mvmt_clk        (mvmt_clk),
    .reset           (reset),
    .en              (en),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .player_addr     (player_addr),
    .respawn_en      (respawn_en),
    .mem_addr        (mem_addr),
    .mem_we          (mem_we),
    .mem_din         (mem_din),
    .mem_dout        (mem_dout),
    .collected_count (collected_count),
    .respawn_busy    (respawn_busy)
  );

  always #5 mvmt_clk = ~mvmt_clk;

  function automatic logic [7:0] nextLfsr(input logic [7:0] x);
    nextLfsr = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  function automatic logic [8:0] cellFor(input logic [1:0] s);
    case (s)
      2'b00:   cellFor = 9'h002;
      2'b01:   cellFor = 9'h004;
      2'b10:   cellFor = 9'h006;
      default: cellFor = 9'h002;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] ra, input logic we, input logic [7:0] wa, input logic [8:0] wd);
    rd_addr = ra;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
  endtask

  task automatic tick();
    @(negedge mvmt_clk);
    if (en && !reset) en_cycles++;
  endtask

  task automatic waitWrap(input string tag);
    int guard = 0;
    while ((en_cycles % BENCH_PERIOD) != BENCH_PERIOD - 1 && guard < 2 * BENCH_PERIOD) begin
      tick();
      guard++;
    end
    checkOutput({tag, "_busy_before"}, 32'(respawn_busy), 32'd0);
    tick();
    checkOutput({tag, "_busy_on_wrap"}, 32'(respawn_busy), 32'd1);
  endtask

  // BRAM model: read-first, synchronous read; wall_mode makes every cell
  // read back as a wall.
  initial begin : bram_model
    for (int i = 0; i < 256; i++) mem[i] = 9'h000;
    mem_dout = 9'h000;
    forever begin
      @(posedge mvmt_clk);
      mem_dout <= wall_mode ? 9'h001 : mem[mem_addr];
      if (load_en) mem[load_addr] = load_val;
      else if (mem_we) mem[mem_addr] = mem_din;
    end
  end

  // Port event monitor: any write or any access not at rd_addr must match
  // the next expected event.
  initial begin : port_monitor
    logic [17:0] obs;
    logic [17:0] exp_ev;
    forever begin
      @(negedge mvmt_clk);
      #2;
      if (!reset && (mem_we || (mem_addr != rd_addr))) begin
        events_seen++;
        obs = {mem_we, mem_addr, mem_din};
        if (ev_q.size() == 0) begin
          checkOutput("unexpected_port_event", 32'(obs), 32'hFFFF_FFFF);
        end else begin
          exp_ev = ev_q.pop_front();
          checkOutput("port_event", 32'(obs), 32'(exp_ev));
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1; en = 1'b0; respawn_en = 1'b0; player_addr = 8'h00;
    wall_mode = 1'b0;
    applyStimulus(8'h00, 1'b0, 8'h00, 9'h000);
    load_en = 1'b1; load_addr = 8'h23; load_val = 9'h005;
    tick();
    load_addr = 8'h11; load_val = 9'h006;
    tick();
    load_addr = 8'h12; load_val = 9'h003;
    tick();
    load_en = 1'b0;

    checkOutput("reset_rd_data",  32'(rd_data), 32'h0);
    checkOutput("reset_mem_we",   32'(mem_we), 32'h0);
    checkOutput("reset_mem_din",  32'(mem_din), 32'h0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("reset_count",    32'(collected_count), 32'h0);
    checkOutput("reset_busy",     32'(respawn_busy), 32'h0);
    checkOutput("reset_lfsr",     32'(dut.u_lfsr.value), 32'hA5);

    // Player read: two edges of latency.
    reset = 1'b0; en = 1'b1;
    applyStimulus(8'h23, 1'b0, 8'h00, 9'h000);
    rd_q.push_back(9'h005);
    tick();
    checkOutput("read_not_early", 32'(rd_data), 32'h0);
    tick();
    checkOutput("read_latency", 32'(rd_data), 32'(rd_q.pop_front()));

    // Player write with bypass to the looked-up cell.
    applyStimulus(8'h23, 1'b1, 8'h23, 9'h001);
    ev_q.push_back({1'b1, 8'h23, 9'h001});
    rd_q.push_back(9'h001);
    #1 checkOutput("write_strobe", 32'(mem_we), 32'h1);
    tick();
    applyStimulus(8'h23, 1'b0, 8'h00, 9'h000);
    checkOutput("write_bypass", 32'(rd_data), 32'(rd_q.pop_front()));
    checkOutput("count_after_write", 32'(collected_count), 32'h1);

    // Respawn into an all-free maze.
    applyStimulus(8'h00, 1'b0, 8'h00, 9'h000);
    tick();
    ev_q.push_back({1'b0, lfsr_m, 9'h000});
    ev_q.push_back({1'b1, lfsr_m, cellFor(lfsr_m[1:0])});
    lfsr_m = nextLfsr(lfsr_m);
    respawn_en = 1'b1;
    waitWrap("free");
    respawn_en = 1'b0;
    tick();
    checkOutput("free_busy_mid", 32'(respawn_busy), 32'h1);
    tick();
    tick();
    checkOutput("free_busy_done", 32'(respawn_busy), 32'h0);
    checkOutput("free_count_back", 32'(collected_count), 32'h0);
    checkOutput("free_events_drained", 32'(ev_q.size()), 32'd0);

    // Every cell a wall: MAX_TRIES probes then give up.
    wall_mode = 1'b1;
    applyStimulus(8'h00, 1'b1, 8'h40, 9'h000);
    ev_q.push_back({1'b1, 8'h40, 9'h000});
    tick();
    applyStimulus(8'h00, 1'b0, 8'h00, 9'h000);
    checkOutput("walls_count_before", 32'(collected_count), 32'h1);
    for (int i = 0; i < 16; i++) begin
      ev_q.push_back({1'b0, lfsr_m, 9'h000});
      lfsr_m = nextLfsr(lfsr_m);
    end
    respawn_en = 1'b1;
    waitWrap("walls");
    respawn_en = 1'b0;
    n = 0;
    while (respawn_busy && n < 40) begin
      tick();
      n++;
    end
    checkOutput("walls_giveup_cycles", 32'(n), 32'd32);
    checkOutput("walls_count_kept", 32'(collected_count), 32'h1);
    checkOutput("walls_events_drained", 32'(ev_q.size()), 32'd0);
    wall_mode = 1'b0;

    // Toggling lookups starve the engine; freezing grants the next cycle.
    respawn_en = 1'b1;
    waitWrap("toggle");
    respawn_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = (i % 2 == 0) ? 8'h11 : 8'h12;
      applyStimulus(a, 1'b0, 8'h00, 9'h000);
      rd_q.push_back((i % 2 == 0) ? 9'h006 : 9'h003);
      tick();
      if (i > 0) checkOutput("toggle_rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
    end
    ev_q.push_back({1'b0, lfsr_m, 9'h000});
    ev_q.push_back({1'b1, lfsr_m, cellFor(lfsr_m[1:0])});
    lfsr_m = nextLfsr(lfsr_m);
    ev_base = events_seen;
    tick();
    checkOutput("grant_on_stable", 32'(events_seen), 32'(ev_base + 1));
    checkOutput("rd_after_freeze", 32'(rd_data), 32'(rd_q.pop_front()));
    tick();
    checkOutput("rd_hold_after_respawn", 32'(rd_data), 32'h003);
    tick();
    checkOutput("toggle_busy_done", 32'(respawn_busy), 32'h0);
    checkOutput("toggle_count_back", 32'(collected_count), 32'h0);
    checkOutput("toggle_events_drained", 32'(ev_q.size()), 32'd0);

    // Reset while waiting for a write grant.
    applyStimulus(8'h00, 1'b1, 8'h50, 9'h000);
    ev_q.push_back({1'b1, 8'h50, 9'h000});
    tick();
    applyStimulus(8'h00, 1'b0, 8'h00, 9'h000);
    ev_q.push_back({1'b0, lfsr_m, 9'h000});
    respawn_en = 1'b1;
    waitWrap("rstmid");
    respawn_en = 1'b0;
    tick();
    applyStimulus(8'h11, 1'b0, 8'h00, 9'h000);
    tick();
    applyStimulus(8'h12, 1'b0, 8'h00, 9'h000);
    #1 checkOutput("write_wait_no_we", 32'(mem_we), 32'h0);
    checkOutput("write_wait_busy", 32'(respawn_busy), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("rstmid_rd_data",  32'(rd_data), 32'h0);
    checkOutput("rstmid_mem_we",   32'(mem_we), 32'h0);
    checkOutput("rstmid_mem_din",  32'(mem_din), 32'h0);
    checkOutput("rstmid_mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("rstmid_count",    32'(collected_count), 32'h0);
    checkOutput("rstmid_busy",     32'(respawn_busy), 32'h0);
    checkOutput("rstmid_lfsr",     32'(dut.u_lfsr.value), 32'hA5);
    checkOutput("rstmid_events_drained", 32'(ev_q.size()), 32'd0);
    tick();
    reset = 1'b0;
    applyStimulus(8'h00, 1'b0, 8'h00, 9'h000);
    tick();
    tick();
    checkOutput("post_reset_busy", 32'(respawn_busy), 32'h0);
    checkOutput("post_reset_count", 32'(collected_count), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
